// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core load/store port (0) and the loader (1).
// Round-robin grant, bounded burst lock for port 1, registered read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_e;

  lock_e             lock_q, lock_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic act;
  logic sel_we;
  logic rd;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (lock_q == LOCKED && cnt_q < CNT_MAX) begin
        gnt1 = 1'b1;
      end else if (last_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    sel_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      sel_we    = we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      sel_we    = we1;
    end
  end

  assign act    = gnt0 | gnt1;
  assign rd     = act & ~sel_we;
  // Held off during reset so nothing can commit to memory.
  assign mem_we = act & sel_we & reset;
  assign mem_re = rd & reset;

  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    last_d = act ? gnt1 : last_q;
    rv0_d  = rd & gnt0;
    rv1_d  = rd & gnt1;
    rd0_d  = (rd & gnt0) ? mem_rdata : rd0_q;
    rd1_d  = (rd & gnt1) ? mem_rdata : rd1_q;
    unique case (lock_q)
      UNLOCKED: begin
        if (gnt1 && lock1) begin
          lock_d = LOCKED;
          cnt_d  = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (gnt0 || !req1 || (gnt1 && !lock1)) begin
          lock_d = UNLOCKED;
          cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        lock_d = UNLOCKED;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= UNLOCKED;
      cnt_q  <= '0;
      last_q <= 1'b1;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end

  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata0  = rd0_q;
  assign rdata1  = rd1_q;

endmodule
